// File: rtl/board_renderer_pipe_if.sv
// Pixel-side bus of board_renderer_pipe: raster position, cursor and board state in, colour out.
// Signal prefixes are from the renderer's point of view (i_ into it, o_ out of it).
interface board_renderer_pipe_if #(
    parameter int N = 5
);
    logic [9:0]       i_x;
    logic [9:0]       i_y;
    logic             i_visible;
    logic             i_frame_tick;
    logic [2:0]       i_cur_i;
    logic [2:0]       i_cur_j;
    logic             i_cur_sel;
    logic [2*N*N-1:0] i_board_a;
    logic [2*N*N-1:0] i_board_b;
    logic [7:0]       o_r;
    logic [7:0]       o_g;
    logic [7:0]       o_b;
    logic             o_rgb_valid;

    modport master (
        output i_x, i_y, i_visible, i_frame_tick, i_cur_i, i_cur_j, i_cur_sel, i_board_a, i_board_b,
        input  o_r, o_g, o_b, o_rgb_valid
    );

    modport slave (
        input  i_x, i_y, i_visible, i_frame_tick, i_cur_i, i_cur_j, i_cur_sel, i_board_a, i_board_b,
        output o_r, o_g, o_b, o_rgb_valid
    );
endinterface

// File: rtl/board_renderer_pipe.sv
// Two-stage VGA pixel generator for two N x N game boards drawn side by side.
// Cell position comes from incremental counters; stage 2 applies cell colour, ship hiding and cursor blink.
module board_renderer_pipe #(
    parameter int N          = 5,
    parameter int CELL       = 58,
    parameter int FRAME      = 2,
    parameter int GAP        = 0,
    parameter int BLINK      = 16,
    parameter int HIDE_SHIPS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    board_renderer_pipe_if.slave io_pix
);
    localparam int P   = CELL + FRAME;
    localparam int OW  = (P > 2) ? $clog2(P) : 1;
    localparam int OW1 = OW + 1;
    localparam int BW  = (N > 1) ? $clog2(2 * N * N) : 1;
    localparam int KW  = (BLINK > 2) ? $clog2(BLINK) : 1;

    localparam logic [OW-1:0] LP_OFF_LAST   = OW'(P - 1);
    localparam logic [OW:0]   LP_FRAME      = OW1'(FRAME);
    localparam logic [OW:0]   LP_CELL       = OW1'(CELL);
    localparam logic [7:0]    LP_A_END      = 8'(N);
    localparam logic [7:0]    LP_B_BEG      = 8'(N + GAP);
    localparam logic [7:0]    LP_B_END      = 8'(2 * N + GAP);
    localparam logic [2:0]    LP_B_BEG3     = 3'(N + GAP);
    localparam logic [KW-1:0] LP_BLINK_LAST = KW'(BLINK - 1);

    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    logic [3:0]    r_hcell, r_vcell, w_hcell, w_vcell;
    logic [OW-1:0] r_hoff, r_voff, w_hoff, w_voff;
    logic          w_line_start, w_on_a, w_on_b, w_row_ok, w_inside, w_cursor;
    logic [7:0]    w_hc8;
    logic [2:0]    w_col;
    logic          r_s1_valid, r_s1_draw, r_s1_board_b, r_s1_cursor;
    logic [2:0]    r_s1_row, r_s1_col;
    logic [KW-1:0] r_blink_cnt;
    logic          r_blink_on;
    logic [BW-1:0] w_bit;
    logic [1:0]    w_state;
    logic [23:0]   w_colour;

    // Reset asserts asynchronously but is released two clocks later, in step with clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    always_comb begin
        w_line_start = io_pix.i_visible && (io_pix.i_x == 10'd0);
        w_hcell      = r_hcell;
        w_hoff       = r_hoff;
        w_vcell      = r_vcell;
        w_voff       = r_voff;
        if (w_line_start) begin
            w_hcell = '0;
            w_hoff  = '0;
        end else if (r_hoff == LP_OFF_LAST) begin
            w_hoff = '0;
            if (r_hcell != 4'hF) w_hcell = r_hcell + 4'd1;
        end else begin
            w_hoff = r_hoff + OW'(1);
        end
        if (w_line_start) begin
            if (io_pix.i_y == 10'd0) begin
                w_vcell = '0;
                w_voff  = '0;
            end else if (r_voff == LP_OFF_LAST) begin
                w_voff = '0;
                if (r_vcell != 4'hF) w_vcell = r_vcell + 4'd1;
            end else begin
                w_voff = r_voff + OW'(1);
            end
        end
    end

    // Column modulo 8 is exact here because a board-B column always lies in 0..N-1.
    always_comb begin
        w_hc8    = {4'd0, w_hcell};
        w_on_a   = w_hc8 < LP_A_END;
        w_on_b   = (w_hc8 >= LP_B_BEG) && (w_hc8 < LP_B_END);
        w_col    = w_on_a ? w_hcell[2:0] : (w_hcell[2:0] - LP_B_BEG3);
        w_row_ok = {4'd0, w_vcell} < LP_A_END;
        w_inside = ({1'b0, w_hoff} >= LP_FRAME) && ({1'b0, w_hoff} < LP_CELL) &&
                   ({1'b0, w_voff} >= LP_FRAME) && ({1'b0, w_voff} < LP_CELL);
        w_cursor = w_inside && w_row_ok && (io_pix.i_cur_sel ? w_on_b : w_on_a) &&
                   (w_vcell[2:0] == io_pix.i_cur_i) && (w_col == io_pix.i_cur_j);
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_hcell      <= '0;
            r_hoff       <= '0;
            r_vcell      <= '0;
            r_voff       <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_draw    <= 1'b0;
            r_s1_board_b <= 1'b0;
            r_s1_cursor  <= 1'b0;
            r_s1_row     <= '0;
            r_s1_col     <= '0;
        end else begin
            if (io_pix.i_visible) begin
                r_hcell <= w_hcell;
                r_hoff  <= w_hoff;
                r_vcell <= w_vcell;
                r_voff  <= w_voff;
            end
            r_s1_valid   <= io_pix.i_visible;
            r_s1_draw    <= w_inside && w_row_ok && (w_on_a || w_on_b);
            r_s1_board_b <= w_on_b;
            r_s1_cursor  <= w_cursor;
            r_s1_row     <= w_vcell[2:0];
            r_s1_col     <= w_col;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b0;
        end else if (io_pix.i_frame_tick) begin
            if (r_blink_cnt == LP_BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + KW'(1);
            end
        end
    end

    // Boards are read here rather than in stage 1, so a board update shows on the very next pixel.
    always_comb begin
        w_bit    = BW'(2 * (int'(r_s1_row) * N + int'(r_s1_col)));
        w_state  = r_s1_board_b ? io_pix.i_board_b[w_bit +: 2] : io_pix.i_board_a[w_bit +: 2];
        w_colour = '0;
        unique case (w_state)
            2'b00:   w_colour = 24'h0000FF;
            2'b01:   w_colour = (r_s1_board_b && HIDE_SHIPS != 0) ? 24'h0000FF : 24'h808080;
            2'b10:   w_colour = 24'hFF0000;
            default: w_colour = 24'hFFFF00;
        endcase
        if (r_s1_cursor && r_blink_on) w_colour = 24'hFFFFFF;
        if (!r_s1_valid || !r_s1_draw) w_colour = 24'h000000;
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            io_pix.o_r         <= '0;
            io_pix.o_g         <= '0;
            io_pix.o_b         <= '0;
            io_pix.o_rgb_valid <= 1'b0;
        end else begin
            {io_pix.o_r, io_pix.o_g, io_pix.o_b} <= w_colour;
            io_pix.o_rgb_valid                   <= r_s1_valid;
        end
    end
endmodule
